board_renderer: RTL and testbench
=================================

# board_renderer

Pixel source for the 360x360 game area: turns the on-screen pixel position into a 24-bit RGB colour for the VGA controller, with zero latency. It holds a 9x9 board of 2-bit cell states, each cell 40x40 px, in two banks: game logic writes the back bank through a valid/ready port, and a commit request swaps banks during vertical sync so a frame never shows half-updated state. It sits directly upstream of the VGA controller: it consumes that block's DISP_EN/X/Y/VGA_VS and drives its RGB input.

## Interface
Parameters:
- CELL_PX, 40: cell edge in pixels (9 x 40 = 360).
- GRID_N, 9: cells per side; 81 cells total.
- C_EMPTY, 24'h202020: colour for state 0.
- C_P1, 24'hE03030: colour for state 1.
- C_P2, 24'h3060E0: colour for state 2.
- C_WALL, 24'hA0A0A0: colour for state 3.
- C_GRID, 24'hFFFFFF: colour for grid lines and for the row/column at index 360.

Ports:
- VGA_CLK  in  1  pixel clock.
- RESET  in  1  synchronous, active-high.
- DISP_EN  in  1  game-area pixel valid.
- X  in  10  game-area column, 0..360.
- Y  in  10  game-area row, 0..360.
- VGA_VS  in  1  vertical sync, active low.
- RGB  out  24  pixel colour, {R,G,B}.
- WR_VALID  in  1  cell write request.
- WR_READY  out  1  write/commit accepted this cycle.
- WR_ADDR  in  7  cell index = row*9 + col, 0..80.
- WR_DATA  in  2  cell state.
- WR_ERR  out  1  one-cycle pulse when an accepted write has WR_ADDR > 80.
- COMMIT  in  1  request bank swap; sampled with WR_READY.
- SWAP_DONE  out  1  one-cycle pulse when the copy completes.

## Operation
- Position tracking uses no divider. The block keeps col/sub_x counters (0..9 / 0..39) and row/sub_y counters.
- Column counters: cleared while DISP_EN=0; advance once per cycle while DISP_EN=1; sub_x wraps at 39 and increments col.
- Row counters: cleared while VGA_VS=0; advance on each DISP_EN falling edge, which requires a registered copy of DISP_EN.
- The counters always describe the current pixel. X and Y are used only for the index-360 edge test and for assertions: sub_x == X mod 40 and col == X/40 whenever DISP_EN=1.
- RGB decode:
  - DISP_EN=0: RGB = 0.
  - X==360, Y==360, sub_x==0 or sub_y==0: RGB = C_GRID.
  - Otherwise: colour of front_bank[row*9+col].
- Control FSM:
  - IDLE: WR_READY=1. An accepted write with WR_ADDR<=80 updates back_bank. COMMIT=1 moves to PENDING.
  - PENDING: WR_READY=0. On the VGA_VS falling edge the bank select flips and the FSM moves to COPY.
  - COPY: WR_READY=0. Copies the new front bank into the new back bank, one cell per cycle, indices 0..80 (81 cycles). Then pulses SWAP_DONE and returns to IDLE.
- A write and COMMIT in the same cycle: the write lands in the back bank before the swap.
- COMMIT or WR_VALID while WR_READY=0: ignored, not queued.
- A write with WR_ADDR > 80 is accepted, storage is unchanged, and WR_ERR pulses.

## Timing
- RGB is combinational from the registered counters, the bank and the inputs. Latency is 0 cycles relative to X/Y/DISP_EN.
- Handshake: a transfer occurs on a clock edge with WR_VALID & WR_READY. WR_ERR follows one cycle after the transfer.
- Swap occurs on the first edge where the registered VGA_VS=1 and the current VGA_VS=0.
- The COPY phase (81 cycles) completes within the 2-line sync pulse, before any displayed line.
- SWAP_DONE is asserted in the cycle after the last copy write.
- Reset values:
  - RGB = 0 while DISP_EN=0.
  - WR_READY=1 and the FSM is in IDLE.
  - WR_ERR=0, SWAP_DONE=0.
  - Bank select = 0.
  - Both banks cleared to state 0.
  - All counters 0.
- Reset mid-PENDING or mid-COPY: the FSM returns to IDLE and both banks are cleared. No SWAP_DONE is issued.

## Structure
- Shared package holds:
  - the state encoding (EMPTY=0, P1=1, P2=2, WALL=3);
  - the GRID_N and CELL_PX constants;
  - the FSM enum (IDLE, PENDING, COPY).
  Game logic imports the same package.
- One sub-module: board_bank_ram. It has two 81x2 register banks with an asynchronous read port (pixel path), a synchronous write port, and a copy read port. The top level holds the counters, colour decode and FSM.

## Test plan
- Reset, then a full frame with no writes -> every DISP_EN pixel is C_EMPTY or C_GRID; the pixel at X=0 is C_GRID; the pixel at X=1, Y=1 is 24'h202020.
- Write addr 10 = P1, COMMIT, run to VGA_VS fall -> SWAP_DONE pulses 81 cycles later. The next frame shows pixel (X=45, Y=45) = 24'hE03030 and (X=85, Y=45) = C_EMPTY.
- Write addr 10 = P2 without COMMIT -> the displayed colour at (45, 45) is unchanged over 2 frames.
- Write addr 90 -> WR_ERR pulses once; both banks are unchanged.
- Drive COMMIT, then hold WR_VALID through PENDING/COPY -> WR_READY=0 throughout and no back-bank change. After SWAP_DONE, WR_READY=1 and the back bank equals the front bank.
- Assert RESET during COPY cycle 40 -> next cycle WR_READY=1, no SWAP_DONE, and all cells read back as state 0.

Source files
------------

// File: rtl/board_renderer_pkg.sv
// Shared definitions for the game board: cell states, grid geometry and the
// bank-swap controller states. Game logic imports this package as well.
package board_renderer_pkg;

  localparam int GRID_N    = 9;
  localparam int CELL_PX   = 40;
  localparam int NUM_CELLS = GRID_N * GRID_N;

  localparam logic [6:0] LAST_CELL = 7'(NUM_CELLS - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2,
    WALL  = 2'd3
  } cell_state_e;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COPY
  } ctrl_state_e;

  // Linear cell index from board row/column.
  function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
    return 7'(row) * 7'(GRID_N) + 7'(col);
  endfunction

endpackage

// File: rtl/board_bank_ram.sv
// Double-buffered 81-cell board store. bank_sel picks the front bank, which
// feeds the asynchronous pixel and copy read ports; writes always go to the
// back bank. Synchronous reset clears both banks.
module board_bank_ram (
  input  logic       clk,
  input  logic       reset,
  input  logic       bank_sel,
  input  logic [6:0] pix_addr,
  output logic [1:0] pix_data,
  input  logic [6:0] copy_addr,
  output logic [1:0] copy_data,
  input  logic       wr_en,
  input  logic [6:0] wr_addr,
  input  logic [1:0] wr_data
);
  import board_renderer_pkg::*;

  logic [1:0] bank0 [NUM_CELLS];
  logic [1:0] bank1 [NUM_CELLS];

  // Clear both banks on reset, otherwise write the back bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (wr_en) begin
      if (bank_sel)
        bank0[wr_addr] <= wr_data;
      else
        bank1[wr_addr] <= wr_data;
    end
  end

  // Front-bank reads; the pixel address can point past the board at the
  // right/bottom edge, where the colour decode ignores it anyway.
  always_comb begin
    pix_data  = '0;
    copy_data = '0;
    if (pix_addr <= LAST_CELL)
      pix_data = bank_sel ? bank1[pix_addr] : bank0[pix_addr];
    if (copy_addr <= LAST_CELL)
      copy_data = bank_sel ? bank1[copy_addr] : bank0[copy_addr];
  end

endmodule

// File: rtl/board_renderer.sv
// Game-area pixel source: tracks the pixel position with counters, decodes
// the front-bank cell colour with zero latency and runs the bank-swap control.
//   state   | meaning
//   IDLE    | accepting writes to the back bank and commit requests
//   PENDING | commit taken, waiting for the vertical sync falling edge
//   COPY    | banks swapped, copying new front into new back (81 cycles)
module board_renderer #(
  parameter logic [23:0] C_EMPTY = 24'h202020,
  parameter logic [23:0] C_P1    = 24'hE03030,
  parameter logic [23:0] C_P2    = 24'h3060E0,
  parameter logic [23:0] C_WALL  = 24'hA0A0A0,
  parameter logic [23:0] C_GRID  = 24'hFFFFFF
) (
  input  logic        VGA_CLK,
  input  logic        RESET,
  input  logic        DISP_EN,
  input  logic [9:0]  X,
  input  logic [9:0]  Y,
  input  logic        VGA_VS,
  output logic [23:0] RGB,
  input  logic        WR_VALID,
  output logic        WR_READY,
  input  logic [6:0]  WR_ADDR,
  input  logic [1:0]  WR_DATA,
  output logic        WR_ERR,
  input  logic        COMMIT,
  output logic        SWAP_DONE
);
  import board_renderer_pkg::*;

  localparam logic [5:0] SUB_LAST = 6'(CELL_PX - 1);
  localparam logic [9:0] EDGE_POS = 10'(GRID_N * CELL_PX);

  logic [5:0]  sub_x, sub_y;
  logic [3:0]  col, row;
  logic        disp_en_q, vs_q;
  logic        vs_fall, line_end;
  ctrl_state_e state_q, state_d;
  logic        bank_sel;
  logic [6:0]  copy_idx;
  logic        swap_now, copy_last;
  logic        ram_wr_en;
  logic [6:0]  ram_wr_addr;
  logic [1:0]  ram_wr_data;
  logic [1:0]  pix_state, copy_state;

  assign vs_fall  = vs_q & ~VGA_VS;
  assign line_end = disp_en_q & ~DISP_EN;

  // Delayed copies of DISP_EN and VGA_VS for edge detection.
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      disp_en_q <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      disp_en_q <= DISP_EN;
      vs_q      <= VGA_VS;
    end
  end

  // Column counters follow the pixel across a displayed line.
  always_ff @(posedge VGA_CLK) begin
    if (RESET || !DISP_EN) begin
      sub_x <= '0;
      col   <= '0;
    end else if (sub_x == SUB_LAST) begin
      sub_x <= '0;
      col   <= col + 4'd1;
    end else begin
      sub_x <= sub_x + 6'd1;
    end
  end

  // Row counters step at the end of each displayed line, restart in vsync.
  always_ff @(posedge VGA_CLK) begin
    if (RESET || !VGA_VS) begin
      sub_y <= '0;
      row   <= '0;
    end else if (line_end) begin
      if (sub_y == SUB_LAST) begin
        sub_y <= '0;
        row   <= row + 4'd1;
      end else begin
        sub_y <= sub_y + 6'd1;
      end
    end
  end

  // Controller state, bank select and copy pointer.
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      bank_sel <= 1'b0;
      copy_idx <= '0;
    end else begin
      state_q <= state_d;
      if (swap_now) begin
        bank_sel <= ~bank_sel;
        copy_idx <= '0;
      end else if (state_q == COPY) begin
        copy_idx <= copy_idx + 7'd1;
      end
    end
  end

  // Next state, handshake and back-bank write source.
  always_comb begin
    state_d     = state_q;
    WR_READY    = 1'b0;
    swap_now    = 1'b0;
    copy_last   = 1'b0;
    ram_wr_en   = 1'b0;
    ram_wr_addr = WR_ADDR;
    ram_wr_data = WR_DATA;
    case (state_q)
      IDLE: begin
        WR_READY = 1'b1;
        if (WR_VALID && (WR_ADDR <= LAST_CELL))
          ram_wr_en = 1'b1;
        if (COMMIT)
          state_d = PENDING;
      end
      PENDING: begin
        if (vs_fall) begin
          swap_now = 1'b1;
          state_d  = COPY;
        end
      end
      COPY: begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = copy_idx;
        ram_wr_data = copy_state;
        if (copy_idx == LAST_CELL) begin
          copy_last = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-cycle status pulses.
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      WR_ERR    <= 1'b0;
      SWAP_DONE <= 1'b0;
    end else begin
      WR_ERR    <= WR_READY && WR_VALID && (WR_ADDR > LAST_CELL);
      SWAP_DONE <= copy_last;
    end
  end

  board_bank_ram u_bank (
    .clk       (VGA_CLK),
    .reset     (RESET),
    .bank_sel  (bank_sel),
    .pix_addr  (cell_index(row, col)),
    .pix_data  (pix_state),
    .copy_addr (copy_idx),
    .copy_data (copy_state),
    .wr_en     (ram_wr_en),
    .wr_addr   (ram_wr_addr),
    .wr_data   (ram_wr_data)
  );

  // Pixel colour: blank, grid line / far edge, or the cell's state colour.
  always_comb begin
    RGB = '0;
    if (DISP_EN) begin
      if (X == EDGE_POS || Y == EDGE_POS || sub_x == '0 || sub_y == '0) begin
        RGB = C_GRID;
      end else begin
        case (pix_state)
          EMPTY:   RGB = C_EMPTY;
          P1:      RGB = C_P1;
          P2:      RGB = C_P2;
          default: RGB = C_WALL;
        endcase
      end
    end
  end

  // The divider-free column tracking must agree with the controller's X.
  assert property (@(posedge VGA_CLK) disable iff (RESET)
    DISP_EN |-> (({4'b0, sub_x} == X % 10'(CELL_PX)) && ({6'b0, col} == X / 10'(CELL_PX))));

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer with a frame-level reference model of
// the displayed board, the handshake and the swap timing.
module tb_board_renderer;

  logic        VGA_CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        DISP_EN = 1'b0;
  logic [9:0]  X = '0;
  logic [9:0]  Y = '0;
  logic        VGA_VS = 1'b1;
  logic [23:0] RGB;
  logic        WR_VALID = 1'b0;
  logic        WR_READY;
  logic [6:0]  WR_ADDR = '0;
  logic [1:0]  WR_DATA = '0;
  logic        WR_ERR;
  logic        COMMIT = 1'b0;
  logic        SWAP_DONE;

  board_renderer dut (
    .VGA_CLK   (VGA_CLK),
    .RESET     (RESET),
    .DISP_EN   (DISP_EN),
    .X         (X),
    .Y         (Y),
    .VGA_VS    (VGA_VS),
    .RGB       (RGB),
    .WR_VALID  (WR_VALID),
    .WR_READY  (WR_READY),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .WR_ERR    (WR_ERR),
    .COMMIT    (COMMIT),
    .SWAP_DONE (SWAP_DONE)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the screen shows and what the handshake must do.
  int unsigned mfront [81];
  int unsigned mback  [81];
  bit model_valid = 0;
  bit busy = 0;
  bit wait_vs = 0;
  int copy_left = 0;
  bit m_vs_prev = 0;
  bit exp_done = 0;
  bit exp_err = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int done_delay = -1;

  logic [23:0] cap_0_1, cap_1_1, cap_45_45, cap_85_45, cap_85_85, cap_125_125;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at t=%0t X=%0d Y=%0d: got %0h, expected %0h", name, $time, X, Y, act, exp);
    end
  endtask

  function automatic logic [23:0] colour(input int unsigned s);
    case (s)
      0:       return 24'h202020;
      1:       return 24'hE03030;
      2:       return 24'h3060E0;
      default: return 24'hA0A0A0;
    endcase
  endfunction

  function automatic logic [23:0] exp_rgb(input logic de, input int x, input int y);
    if (!de) return 24'h0;
    if (x == 360 || y == 360 || (x % 40) == 0 || (y % 40) == 0) return 24'hFFFFFF;
    return colour(mfront[(y / 40) * 9 + (x / 40)]);
  endfunction

  // Advance the model at each clock edge from the inputs seen at that edge.
  always @(posedge VGA_CLK) begin
    bit ready_pre;
    cyc++;
    exp_done = 0;
    exp_err  = 0;
    if (RESET) begin
      for (int i = 0; i < 81; i++) begin
        mfront[i] = 0;
        mback[i]  = 0;
      end
      busy = 0; wait_vs = 0; copy_left = 0; m_vs_prev = 0;
      model_valid = 1;
    end else begin
      ready_pre = !busy;
      if (m_vs_prev && !VGA_VS) last_fall_cyc = cyc;
      if (wait_vs && m_vs_prev && !VGA_VS) begin
        // After swap + copy both banks hold what was written before commit.
        for (int i = 0; i < 81; i++) mfront[i] = mback[i];
        wait_vs = 0;
        copy_left = 81;
      end else if (copy_left > 0) begin
        copy_left--;
        if (copy_left == 0) begin
          busy = 0;
          exp_done = 1;
        end
      end
      if (ready_pre && WR_VALID) begin
        if (WR_ADDR <= 80) mback[WR_ADDR] = WR_DATA;
        else exp_err = 1;
      end
      if (ready_pre && COMMIT) begin
        busy = 1;
        wait_vs = 1;
      end
      m_vs_prev = VGA_VS;
    end
  end

  // Compare every output on the falling edge.
  always @(negedge VGA_CLK) begin
    if (model_valid) begin
      check("rgb", {8'h0, RGB}, {8'h0, exp_rgb(DISP_EN, int'(X), int'(Y))});
      check("wr_ready", {31'h0, WR_READY}, {31'h0, !busy});
      check("swap_done", {31'h0, SWAP_DONE}, {31'h0, exp_done});
      check("wr_err", {31'h0, WR_ERR}, {31'h0, exp_err});
      if (DISP_EN) begin
        if (X == 0   && Y == 1)   cap_0_1     = RGB;
        if (X == 1   && Y == 1)   cap_1_1     = RGB;
        if (X == 45  && Y == 45)  cap_45_45   = RGB;
        if (X == 85  && Y == 45)  cap_85_45   = RGB;
        if (X == 85  && Y == 85)  cap_85_85   = RGB;
        if (X == 125 && Y == 125) cap_125_125 = RGB;
      end
      if (SWAP_DONE) done_delay = cyc - last_fall_cyc;
    end
  end

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  function automatic int line_width(input int y);
    if (y == 1 || y == 200 || y == 360) return 361;
    if (y == 44 || y == 45 || y == 46 || y == 85 || y == 125) return 130;
    return 2;
  endfunction

  // One frame: 100-cycle vsync pulse, then 361 lines of varying width.
  task automatic frame();
    cap_0_1 = '0; cap_1_1 = '0; cap_45_45 = '0;
    cap_85_45 = '0; cap_85_85 = '0; cap_125_125 = '0;
    done_delay = -1;
    VGA_VS = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (SWAP_DONE) WR_VALID = 1'b0;
    end
    VGA_VS = 1'b1;
    tick(); tick();
    for (int y = 0; y <= 360; y++) begin
      for (int x = 0; x < line_width(y); x++) begin
        DISP_EN = 1'b1;
        X = 10'(x);
        Y = 10'(y);
        tick();
      end
      DISP_EN = 1'b0;
      tick(); tick();
    end
  endtask

  task automatic write_cell(input int addr, input int data);
    WR_VALID = 1'b1;
    WR_ADDR = 7'(addr);
    WR_DATA = 2'(data);
    tick();
    WR_VALID = 1'b0;
  endtask

  task automatic commit();
    COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
  endtask

  initial begin
    int cnt;
    tick(); tick(); tick();
    RESET = 1'b0;
    @(negedge VGA_CLK);
    check("reset_ready", {31'h0, WR_READY}, 32'h1);
    check("reset_done", {31'h0, SWAP_DONE}, 32'h0);
    check("reset_err", {31'h0, WR_ERR}, 32'h0);
    check("reset_rgb", {8'h0, RGB}, 32'h0);
    tick();

    // Empty board frame.
    frame();
    check("empty_x0_grid", {8'h0, cap_0_1}, 32'hFFFFFF);
    check("empty_x1y1", {8'h0, cap_1_1}, 32'h202020);

    // Write P1 at cell 10, commit, swap in the next vsync.
    write_cell(10, 1);
    commit();
    frame();
    check("swap_delay", done_delay, 81);
    check("p1_at_45_45", {8'h0, cap_45_45}, 32'hE03030);
    check("empty_at_85_45", {8'h0, cap_85_45}, 32'h202020);

    // Back-bank write without commit stays invisible.
    write_cell(10, 2);
    frame();
    check("nocommit_f1", {8'h0, cap_45_45}, 32'hE03030);
    frame();
    check("nocommit_f2", {8'h0, cap_45_45}, 32'hE03030);

    // Out-of-range write: one error pulse.
    WR_VALID = 1'b1; WR_ADDR = 7'd90; WR_DATA = 2'd3;
    tick();
    WR_VALID = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cnt += int'(WR_ERR);
      tick();
    end
    check("err_pulses", cnt, 1);

    // Write + commit together, then hold a write through PENDING/COPY.
    WR_VALID = 1'b1; WR_ADDR = 7'd30; WR_DATA = 2'd1; COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
    WR_ADDR = 7'd20; WR_DATA = 2'd3;
    frame();
    WR_VALID = 1'b0;
    check("swap_delay2", done_delay, 81);
    check("p2_at_45_45", {8'h0, cap_45_45}, 32'h3060E0);
    check("p1_at_125_125", {8'h0, cap_125_125}, 32'hE03030);
    check("blocked_85_85", {8'h0, cap_85_85}, 32'h202020);

    // Commit with no new writes: the copied back bank must match.
    commit();
    frame();
    check("recommit_45_45", {8'h0, cap_45_45}, 32'h3060E0);
    check("recommit_125_125", {8'h0, cap_125_125}, 32'hE03030);

    // Reset in the middle of the copy.
    write_cell(0, 3);
    commit();
    VGA_VS = 1'b0;
    tick();
    for (int i = 0; i < 40; i++) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("rst_copy_ready", {31'h0, WR_READY}, 32'h1);
    check("rst_copy_done", {31'h0, SWAP_DONE}, 32'h0);
    VGA_VS = 1'b1;
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      cnt += int'(SWAP_DONE);
      tick();
    end
    check("rst_no_done", cnt, 0);
    frame();
    check("rst_cleared_45_45", {8'h0, cap_45_45}, 32'h202020);
    check("rst_cleared_1_1", {8'h0, cap_1_1}, 32'h202020);
    commit();
    frame();
    check("rst_back_45_45", {8'h0, cap_45_45}, 32'h202020);
    check("rst_back_125_125", {8'h0, cap_125_125}, 32'h202020);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
